bvb_arbiter: RTL and testbench

BVB_ARBITER -- requirements
Module: bvb_arbiter

---
 rtl/bvb_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/bvb_arbiter.sv | 70 +++++++
 tb/tb_bvb_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bvb_pkg.sv
// bvb_pkg: shared defaults and slot-state encoding for the bvb arbiter
package bvb_pkg;
  localparam int LANES = 4;
  localparam int ID_W = 10;
  localparam int VAL_W = 8;
  typedef enum logic [1:0] {EMPTY = 2'd0, PEND = 2'd1, FULL = 2'd2} slot_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of one requester, searching from last_grant+1
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);
  // scan from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    grant_valid = 1'b0;
    grant_idx = '0;
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last_grant) + i) % N);
      if (req[j]) begin
        grant_valid = 1'b1;
        grant_idx = j;
      end
    end
  end
endmodule

// File: rtl/bvb_arbiter.sv
// bvb_arbiter: round-robin sharing of one value memory among per-lane index FIFOs
module bvb_arbiter import bvb_pkg::*; #(
  parameter int LANES = bvb_pkg::LANES,
  parameter int ID_W = bvb_pkg::ID_W,
  parameter int VAL_W = bvb_pkg::VAL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*ID_W-1:0]  id,
  input  logic [LANES-1:0]       id_empty,
  output logic [LANES-1:0]       id_read,
  output logic                   mem_en,
  output logic [ID_W-1:0]        mem_addr,
  input  logic [VAL_W-1:0]       mem_data,
  output logic [LANES*VAL_W-1:0] val,
  output logic [LANES-1:0]       val_empty,
  input  logic [LANES-1:0]       val_read
);
  localparam int IW = LANES > 1 ? $clog2(LANES) : 1;
  slot_t st [LANES];
  logic [VAL_W-1:0] v [LANES];
  logic [LANES-1:0] req;
  logic [IW-1:0] last, gi, fl;
  logic gv, fv;
  // eligibility from registered slot state only; result slots packed out
  always_comb begin
    req = '0;
    val_empty = '0;
    val = '0;
    for (int k = 0; k < LANES; k++) begin
      req[k] = !id_empty[k] && st[k] == EMPTY && !rst;
      val_empty[k] = st[k] != FULL;
      val[k*VAL_W +: VAL_W] = v[k];
    end
  end
  rr_arbiter #(.N(LANES), .IW(IW)) u_rr (
    .req(req),
    .last_grant(last),
    .grant_valid(gv),
    .grant_idx(gi)
  );
  assign id_read = gv ? LANES'(1) << gi : '0;
  assign mem_en = gv;
  assign mem_addr = id[gi*ID_W +: ID_W];
  // slot FSMs, in-flight record and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv <= 1'b0;
      fl <= '0;
      last <= IW'(LANES - 1);
      for (int k = 0; k < LANES; k++) begin
        st[k] <= EMPTY;
        v[k] <= '0;
      end
    end else begin
      fv <= gv;
      if (gv) begin
        fl <= gi;
        last <= gi;
      end
      for (int k = 0; k < LANES; k++) begin
        if (fv && fl == IW'(k)) begin
          st[k] <= FULL;
          v[k] <= mem_data;
        end else if (gv && gi == IW'(k)) st[k] <= PEND;
        else if (st[k] == FULL && val_read[k]) st[k] <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_bvb_arbiter.sv
// tb_bvb_arbiter: directed phases with random traffic against a count-based reference model
module tb_bvb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [39:0] id;
  logic [3:0] id_empty, id_read, val_empty, val_read;
  logic mem_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_data;
  logic [31:0] val;
  logic [7:0] mem [1024];
  int total = 0, bad = 0;
  int g[4], p[4], gc[4], lane_mode[4], rd_mode[4];
  int q[4][$];
  int e[4][$];
  int last, cyc, refill;
  bit last_ev;
  int last_eg;
  bit found;

  bvb_arbiter dut (
    .clk(clk), .rst(rst), .id(id), .id_empty(id_empty), .id_read(id_read),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .val(val), .val_empty(val_empty), .val_read(val_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, x);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      g[k] = 0;
      p[k] = 0;
      gc[k] = 0;
      e[k].delete();
    end
    last = 3;
  endtask

  task automatic set_modes(input int l0, l1, l2, l3, input int r0, r1, r2, r3);
    lane_mode[0] = l0; lane_mode[1] = l1; lane_mode[2] = l2; lane_mode[3] = l3;
    rd_mode[0] = r0; rd_mode[1] = r1; rd_mode[2] = r2; rd_mode[3] = r3;
  endtask

  task automatic step();
    bit pres[4], full[4];
    bit ev;
    int eg, j;
    logic [3:0] exp_ir, exp_ve;
    for (int k = 0; k < 4; k++) begin
      if (refill != 0 && lane_mode[k] != 0 && q[k].size() < 2) q[k].push_back($urandom_range(0, 1023));
      case (lane_mode[k])
        1: pres[k] = 1'b1;
        2: pres[k] = 1'($urandom_range(0, 1));
        3: pres[k] = (cyc % 2) == 0;
        default: pres[k] = 1'b0;
      endcase
      pres[k] = pres[k] && q[k].size() > 0;
      id_empty[k] = !pres[k];
      id[k*10 +: 10] = q[k].size() > 0 ? 10'(q[k][0]) : 10'($urandom_range(0, 1023));
      val_read[k] = rd_mode[k] == 1 ? 1'b1 : rd_mode[k] == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    #3;
    ev = 1'b0;
    eg = 0;
    for (int i = 1; i <= 4; i++) begin
      j = (last + i) % 4;
      if (!ev && pres[j] && g[j] == p[j]) begin
        ev = 1'b1;
        eg = j;
      end
    end
    exp_ir = ev ? 4'(1 << eg) : 4'h0;
    chk("id_read", 64'(id_read), 64'(exp_ir));
    chk("mem_en", 64'(mem_en), 64'(ev));
    if (ev) chk("mem_addr", 64'(mem_addr), 64'(q[eg][0]));
    for (int k = 0; k < 4; k++) begin
      full[k] = g[k] > p[k] && cyc >= gc[k] + 2;
      exp_ve[k] = !full[k];
    end
    chk("val_empty", 64'(val_empty), 64'(exp_ve));
    for (int k = 0; k < 4; k++)
      if (full[k]) chk($sformatf("val%0d", k), 64'(val[k*8 +: 8]), 64'(mem[e[k][0]]));
    @(posedge clk);
    if (ev) begin
      e[eg].push_back(q[eg].pop_front());
      g[eg]++;
      gc[eg] = cyc;
      last = eg;
    end
    for (int k = 0; k < 4; k++)
      if (full[k] && val_read[k]) begin
        void'(e[k].pop_front());
        p[k]++;
      end
    last_ev = ev;
    last_eg = eg;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_val_empty", 64'(val_empty), 64'hf);
    chk("rst_val", 64'(val), 64'h0);
    chk("rst_id_read", 64'(id_read), 64'h0);
    chk("rst_mem_en", 64'(mem_en), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(0, 255));
    mem[5] = 8'hA5;
    rst = 1'b1;
    id = '0;
    id_empty = 4'hf;
    val_read = 4'h0;
    cyc = 0;
    refill = 0;
    set_modes(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("init_val_empty", 64'(val_empty), 64'hf);
    chk("init_val", 64'(val), 64'h0);
    chk("init_mem_en", 64'(mem_en), 64'h0);
    rst = 1'b0;
    model_reset();
    q[0].push_back(5);
    set_modes(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk("single_val0", 64'(val[7:0]), 64'hA5);
    set_modes(0, 0, 0, 0, 1, 1, 1, 1);
    repeat (3) step();
    do_reset();
    refill = 1;
    set_modes(1, 1, 1, 1, 0, 0, 0, 0);
    repeat (8) step();
    set_modes(0, 0, 0, 0, 1, 1, 1, 1);
    repeat (3) step();
    set_modes(1, 0, 1, 0, 1, 1, 1, 1);
    repeat (20) step();
    set_modes(2, 1, 2, 2, 2, 0, 2, 2);
    repeat (20) step();
    set_modes(0, 0, 0, 0, 1, 1, 1, 1);
    repeat (3) step();
    set_modes(0, 0, 0, 1, 1, 1, 1, 1);
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      step();
      found = last_ev && last_eg == 3;
    end
    total++;
    if (!found) begin
      bad++;
      $error("FAIL lane3_grant_timeout: got none expected grant");
    end
    do_reset();
    set_modes(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    set_modes(2, 2, 3, 2, 2, 2, 2, 2);
    repeat (40) step();
    set_modes(2, 2, 2, 2, 2, 2, 2, 2);
    repeat (300) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
